// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundles the write-port arbiter's bus signals.
//   pipe_*     : pipeline writeback request (valid, dest reg, data)
//   ml_*       : long-latency result push (valid/ready handshake, dest reg, data)
//   stall_pipe : upstream pipeline must hold and re-present its writeback
//   rf_*       : registered register-file write port
//   q_count    : result FIFO occupancy
//   qry_*      : hazard query against queued long-latency results
//   Modport slave is the arbiter side; master is the driver/observer side.
interface wb_port_arbiter_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pipe_we;
  logic [4:0]    pipe_rd;
  logic [DW-1:0] pipe_data;
  logic          ml_valid;
  logic [4:0]    ml_rd;
  logic [DW-1:0] ml_data;
  logic          ml_ready;
  logic          stall_pipe;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [CW-1:0] q_count;
  logic [4:0]    qry_rd;
  logic          qry_pending;

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, ml_valid, ml_rd, ml_data, qry_rd,
    output ml_ready, stall_pipe, rf_we, rf_rd, rf_wdata, q_count, qry_pending
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data, ml_valid, ml_rd, ml_data, qry_rd,
    input  ml_ready, stall_pipe, rf_we, rf_rd, rf_wdata, q_count, qry_pending
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order
//   pipeline writeback and a long-latency (mul/div) unit. Pipeline writes
//   win; long-latency results wait in a DEPTH-entry FIFO and drain into
//   idle write-port cycles. Output is registered (1-cycle latency).
//   Ports: clk, reset (async, active-high), bus (wb_port_arbiter_if.slave).
//   Optional feature: define WB_ARB_STARVE_GUARD_EN to enable the
//   starvation guard, which stalls the pipeline for one cycle to force a
//   FIFO pop once the head has waited MAX_WAIT cycles. Without it the FIFO
//   drains only on idle pipeline cycles and stall_pipe is tied low.
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int DW       = 32
) (
  input  logic             clk,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem_rd   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          stall_q;
  logic          nonempty, pipe_wr, push, pop;

  assign nonempty     = (count != '0);
  // Registered occupancy only: a pop in this cycle does not open a slot.
  assign bus.ml_ready = (count < CW'(DEPTH));
  // x0 results complete the handshake but are never stored.
  assign push         = bus.ml_valid && bus.ml_ready && (bus.ml_rd != 5'd0);
  assign pipe_wr      = bus.pipe_we && (bus.pipe_rd != 5'd0);
  // A stall cycle forces the head out and ignores the pipeline request.
  assign pop          = nonempty && (stall_q || !pipe_wr);

  assign bus.q_count    = count;
  assign bus.stall_pipe = stall_q;

  // Storage is not reset; validity comes from count/pointers only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= bus.ml_rd;
      mem_data[wr_ptr] <= bus.ml_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_rd    <= '0;
      bus.rf_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      bus.rf_we <= pop || (pipe_wr && !stall_q);
      if (pop) begin
        bus.rf_rd    <= mem_rd[rd_ptr];
        bus.rf_wdata <= mem_data[rd_ptr];
      end else if (pipe_wr && !stall_q) begin
        bus.rf_rd    <= bus.pipe_rd;
        bus.rf_wdata <= bus.pipe_data;
      end else begin
        bus.rf_rd    <= '0;
        bus.rf_wdata <= '0;
      end
    end
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  // wait_cnt counts cycles the head sat unpopped; on reaching MAX_WAIT-1
  // without a pop, the next cycle is a one-shot stall that drains the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      stall_q <= nonempty && !pop && (wait_cnt == WW'(MAX_WAIT - 1));
      if (!nonempty || pop) wait_cnt <= '0;
      else                  wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  // Hazard query: entry i is live when its distance from the head is
  // below the occupancy.
  logic [DEPTH-1:0] hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_qry
    logic [AW-1:0] off;
    assign off    = AW'(i) - rd_ptr;
    assign hit[i] = ({1'b0, off} < count) && (mem_rd[i] == bus.qry_rd);
  end
  assign bus.qry_pending = (|hit) && (bus.qry_rd != 5'd0);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus hand sequences for
// reset, capacity (guard off) or starvation stall (guard on).
module tb_wb_port_arbiter;
  localparam int DW = 32, DEPTH = 4, MAX_WAIT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .DW(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic        pw;  logic [4:0] prd; logic [31:0] pd;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic [4:0]  q;
    logic        e_we; logic [4:0] e_rd; logic [31:0] e_data;
    int          e_cnt; logic e_rdy; logic e_pend;
  } vec_t;

  vec_t tbl[12];
  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] q);
    bus.pipe_we = pw; bus.pipe_rd = prd; bus.pipe_data = pd;
    bus.ml_valid = mv; bus.ml_rd = mrd; bus.ml_data = md;
    bus.qry_rd = q;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    //          pw prd  pd            mv mrd md      q  | we rd  data          cnt rdy pend
    tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,      0,   1, 5,  32'hDEADBEEF, 0, 1, 0};
    tbl[1]  = '{0, 0,  0,            1, 7,  32'h11, 9,   0, 0,  0,            1, 1, 0};
    tbl[2]  = '{1, 3,  32'hA5,       1, 9,  32'h22, 9,   1, 3,  32'hA5,       2, 1, 1};
    tbl[3]  = '{0, 0,  0,            0, 0,  0,      9,   1, 7,  32'h11,       1, 1, 1};
    tbl[4]  = '{0, 0,  0,            0, 0,  0,      9,   1, 9,  32'h22,       0, 1, 0};
    tbl[5]  = '{1, 4,  32'h44,       1, 12, 32'h33, 12,  1, 4,  32'h44,       1, 1, 1};
    tbl[6]  = '{1, 0,  32'h99,       1, 0,  32'h77, 12,  1, 12, 32'h33,       0, 1, 0};
    tbl[7]  = '{0, 0,  0,            1, 0,  32'h77, 0,   0, 0,  0,            0, 1, 0};
    tbl[8]  = '{0, 0,  0,            1, 1,  32'h1,  2,   0, 0,  0,            1, 1, 0};
    tbl[9]  = '{0, 0,  0,            1, 2,  32'h2,  2,   1, 1,  32'h1,        1, 1, 1};
    tbl[10] = '{0, 0,  0,            0, 0,  0,      2,   1, 2,  32'h2,        0, 1, 0};
    tbl[11] = '{1, 0,  32'h5,        0, 0,  0,      0,   0, 0,  0,            0, 1, 0};

    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #12 reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("idle_c%0d", c), {bus.rf_we, bus.q_count, bus.ml_ready, bus.stall_pipe},
          {1'b0, 3'd0, 1'b1, 1'b0});
    end

    // Vector table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].pw, tbl[i].prd, tbl[i].pd, tbl[i].mv, tbl[i].mrd, tbl[i].md, tbl[i].q);
      tick();
      chk($sformatf("v%0d_we", i), bus.rf_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d_rd", i), bus.rf_rd, tbl[i].e_rd);
        chk($sformatf("v%0d_data", i), bus.rf_wdata, tbl[i].e_data);
      end
      chk($sformatf("v%0d_cnt", i), bus.q_count, tbl[i].e_cnt);
      chk($sformatf("v%0d_rdy", i), bus.ml_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_pend", i), bus.qry_pending, tbl[i].e_pend);
    end

    // Asynchronous reset with three queued results
    for (int k = 0; k < 3; k++) begin
      drive(1, 6, 32'h66, 1, 5'(10 + k), 32'(k), 0);
      tick();
    end
    chk("mr_cnt_pre", bus.q_count, 3);
    chk("mr_we_pre", bus.rf_we, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("mr_we", bus.rf_we, 0);
    chk("mr_rd", bus.rf_rd, 0);
    chk("mr_data", bus.rf_wdata, 0);
    chk("mr_cnt", bus.q_count, 0);
    chk("mr_stall", bus.stall_pipe, 0);
    #10 reset = 1'b0;
    tick();
    chk("mr_post_we", bus.rf_we, 0);
    chk("mr_post_cnt", bus.q_count, 0);

`ifndef WB_ARB_STARVE_GUARD_EN
    // Capacity: sustained pipeline writes fill the FIFO
    for (int k = 0; k < 5; k++) begin
      drive(1, 20, 32'hC0, 1, 5'(21 + k), 32'h100 + 32'(k), 0);
      chk($sformatf("cap_rdy%0d", k), bus.ml_ready, (k < 4));
      tick();
      chk($sformatf("cap_pipe%0d", k), {bus.rf_we, bus.rf_rd}, {1'b1, 5'd20});
    end
    chk("cap_cnt", bus.q_count, 4);
    chk("cap_full", bus.ml_ready, 0);
    chk("cap_stall", bus.stall_pipe, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("drain%0d_we", k), bus.rf_we, 1);
      chk($sformatf("drain%0d_rd", k), bus.rf_rd, 21 + k);
      chk($sformatf("drain%0d_data", k), bus.rf_wdata, 32'h100 + 32'(k));
    end
    chk("drain_cnt", bus.q_count, 0);
    chk("drain_rdy", bus.ml_ready, 1);
    tick();
    chk("drain_idle", bus.rf_we, 0);
`else
    // Starvation guard: one queued result under continuous pipeline writes
    drive(1, 20, 32'hC0, 1, 30, 32'hABC, 0);
    tick();
    drive(1, 20, 32'hC0, 0, 0, 0, 0);
    found = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.stall_pipe) begin
        found = n;
        break;
      end
    end
    chk("guard_delay", found, 8);
    chk("guard_cnt_stall", bus.q_count, 1);
    tick();
    chk("guard_we", bus.rf_we, 1);
    chk("guard_rd", bus.rf_rd, 30);
    chk("guard_data", bus.rf_wdata, 32'hABC);
    chk("guard_stall_off", bus.stall_pipe, 0);
    chk("guard_cnt", bus.q_count, 0);
    tick();
    chk("guard_pipe_resume", bus.rf_rd, 20);
    drive(0, 0, 0, 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback path and a long-latency execution unit (multiply/divide).
- Pipeline writebacks have priority. Long-latency results are buffered in a small FIFO and drained into idle write-port cycles.
- A starvation guard briefly stalls the pipeline so buffered results cannot wait forever.
- Sits between the writeback stage and the register file.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)
- MAX_WAIT, 8, cycles a non-empty FIFO head may wait before the guard forces a drain (>=2)
- DW, 32, data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pipe_we  in  1  pipeline writeback valid
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  DW  pipeline writeback data
- ml_valid  in  1  long-latency result valid
- ml_rd  in  5  long-latency destination register
- ml_data  in  DW  long-latency result data
- ml_ready  out  1  FIFO can accept a result this cycle
- stall_pipe  out  1  registered; upstream pipeline must hold and re-present its writeback
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_wdata  out  DW  register-file write data (registered)
- q_count  out  clog2(DEPTH)+1  FIFO occupancy
- qry_rd  in  5  hazard query register
- qry_pending  out  1  combinational; any queued entry has rd == qry_rd and qry_rd != 0

Behaviour:
- Reset values:
  - rf_we=0, rf_rd=0, rf_wdata=0, stall_pipe=0, q_count=0
  - FIFO pointers 0, wait counter 0
  - FIFO contents discarded, including a reset asserted mid-operation
- FIFO accept:
  - ml_ready = (q_count < DEPTH), from registered occupancy only. A same-cycle pop does not raise ml_ready.
  - Push on ml_valid && ml_ready.
  - ml_rd==0 results are handshaken (accepted) but not stored.
- Pipeline write with pipe_rd==0 is treated as pipe_we=0.
- Per-cycle port selection (priority order):
  1. stall_pipe==1: pop the FIFO head to the port; pipe_we is ignored that cycle.
  2. Else pipe_we==1: pipeline write.
  3. Else q_count>0: pop the FIFO head.
  4. Else: no write.
- Output latency: exactly 1 cycle. Selection in cycle N appears on rf_we/rf_rd/rf_wdata in cycle N+1. rf_we=0 on cycles with no write.
- Simultaneous push and pop: both take effect, q_count unchanged. A push into an empty FIFO cannot be popped in the same cycle.
- Pointers wrap modulo DEPTH.
- Starvation guard:
  - wait_cnt increments each cycle the FIFO is non-empty and no pop occurs.
  - wait_cnt clears on any pop or when the FIFO is empty.
  - When wait_cnt == MAX_WAIT-1 and no pop occurs this cycle, stall_pipe is set for the next cycle.
  - stall_pipe is high for exactly one cycle and always pops the head.
- qry_pending compares only valid FIFO entries. It does not include the registered output stage.
- FIFO order is strict FIFO; results from the long-latency unit are never reordered.

Optional Feature:
- Macro WB_ARB_STARVE_GUARD_EN.
- Defined: starvation guard as above.
- Undefined:
  - stall_pipe is tied to 0 and wait_cnt is removed.
  - FIFO drains only on idle pipeline cycles. Sustained pipe_we can fill the FIFO, and ml_ready then stays low until an idle cycle.

Test Plan:
- Reset then idle, no requests: rf_we=0, q_count=0, ml_ready=1, stall_pipe=0 for 20 cycles. Assert reset mid-stream with q_count=3: all outputs 0 and q_count=0 asynchronously, before the next edge.
- pipe_we=1, pipe_rd=5, pipe_data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
- FIFO drain ordering: push ml_rd=7/data 0x11 and ml_rd=9/data 0x22 with pipe_we=0 -> writes rd 7 then rd 9 on consecutive cycles. qry_rd=9 -> qry_pending=1 until rd 9 is popped.
- Capacity: pipe_we=1 continuously, push 5 results with DEPTH=4, guard off -> q_count=4, ml_ready=0 on the 5th. Drop pipe_we -> four writes in order, then ml_ready=1.
- Guard on, MAX_WAIT=8: pipe_we=1 continuously, one queued result -> stall_pipe=1 for one cycle, 8 cycles after the push. The queued result is written the following cycle and pipe_we is ignored during stall.
- Zero register: pipe_rd=0 with pipe_we=1 and one queued entry -> FIFO head written instead. ml_rd=0 push -> ml_ready handshake completes, q_count unchanged.
